// File: rtl/if_fetch.sv
// Instruction-fetch stage: assembles 32-bit words from a byte-wide memory port, holds them for IF/ID.
// Optional direct-mapped I-cache enabled by defining IF_ICACHE_EN.
module if_fetch #(
  parameter logic [31:0] RESET_PC     = 32'h0000_0000,
  parameter int unsigned ICACHE_LINES = 64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stl_mm,
  input  logic        jmp_en,
  input  logic [31:0] jmp_pc,
  output logic        mif_req,
  output logic [31:0] mif_addr,
  input  logic [7:0]  mif_rdata,
  input  logic        mif_rvalid,
  output logic [31:0] if_pc,
  output logic [31:0] if_is,
  output logic [31:0] if_ppc,
  output logic [1:0]  mmif_ok
);

  typedef enum logic [0:0] {StFetch, StHold} state_e;

  state_e      state_q;
  logic [31:0] pc_q;
  logic [31:0] is_q;
  logic [1:0]  idx_q;
  logic [1:0]  ok_q;
  // One dead request cycle after reset or a redirect before the fetch restarts.
  logic        gap_q;

  logic        hit;
  logic [31:0] hit_word;

  if ((ICACHE_LINES < 2) || ((ICACHE_LINES & (ICACHE_LINES - 1)) != 0)) begin : g_bad_lines
    $error("ICACHE_LINES must be a power of two >= 2");
  end

`ifdef IF_ICACHE_EN
  localparam int unsigned IdxW = $clog2(ICACHE_LINES);
  localparam int unsigned TagW = 30 - IdxW;

  logic [31:0]             data_q [ICACHE_LINES];
  logic [TagW-1:0]         tag_q  [ICACHE_LINES];
  logic [ICACHE_LINES-1:0] valid_q;
  logic [IdxW-1:0]         pc_idx;
  logic [TagW-1:0]         pc_tag;
  logic                    fill;

  assign pc_idx = pc_q[IdxW+1:2];
  assign pc_tag = pc_q[31:IdxW+2];

  // Misaligned PCs bypass the cache so they never alias the aligned word.
  assign hit      = (state_q == StFetch) && !gap_q && valid_q[pc_idx] &&
                    (tag_q[pc_idx] == pc_tag) && (pc_q[1:0] == 2'b00);
  assign hit_word = data_q[pc_idx];
  assign fill     = rst && !jmp_en && mif_req && mif_rvalid && (idx_q == 2'd3) &&
                    (pc_q[1:0] == 2'b00);

  always_ff @(posedge clk) begin
    if (fill) begin
      data_q[pc_idx] <= {mif_rdata, is_q[23:0]};
      tag_q[pc_idx]  <= pc_tag;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      valid_q <= '0;
    end else if (fill) begin
      valid_q[pc_idx] <= 1'b1;
    end
  end
`else
  assign hit      = 1'b0;
  assign hit_word = '0;
`endif

  assign mif_req  = (state_q == StFetch) && !gap_q && !hit;
  assign mif_addr = pc_q + {30'd0, idx_q};
  assign if_pc    = pc_q;
  assign if_ppc   = pc_q + 32'd4;
  assign if_is    = is_q;
  assign mmif_ok  = ok_q;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= StFetch;
      pc_q    <= RESET_PC;
      idx_q   <= 2'd0;
      gap_q   <= 1'b1;
      is_q    <= '0;
      ok_q    <= 2'b00;
    end else if (jmp_en) begin
      // Redirect beats stall and a coincident final byte; any in-flight byte is dropped.
      state_q <= StFetch;
      pc_q    <= jmp_pc;
      idx_q   <= 2'd0;
      gap_q   <= 1'b1;
      ok_q    <= 2'b00;
    end else begin
      case (state_q)
        StFetch: begin
          if (gap_q) begin
            gap_q <= 1'b0;
          end else if (hit) begin
            is_q    <= hit_word;
            ok_q    <= 2'b10;
            state_q <= StHold;
          end else if (mif_rvalid) begin
            is_q[8*idx_q +: 8] <= mif_rdata;
            idx_q              <= idx_q + 2'd1;
            if (idx_q == 2'd3) begin
              ok_q    <= 2'b01;
              state_q <= StHold;
            end
          end
        end
        StHold: begin
          if (!stl_mm) begin
            pc_q    <= pc_q + 32'd4;
            idx_q   <= 2'd0;
            ok_q    <= 2'b00;
            state_q <= StFetch;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_if_fetch.sv
// Self-checking bench for if_fetch: byte memory responder, scoreboard of consumed instructions.
module tb_if_fetch;

  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam int unsigned LINES    = 64;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] is_w;
    logic [31:0] ppc;
    logic [1:0]  ok;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        stl_mm = 1'b1;
  logic        jmp_en = 1'b0;
  logic [31:0] jmp_pc = '0;
  logic        mif_req;
  logic [31:0] mif_addr;
  logic [7:0]  mif_rdata = '0;
  logic        mif_rvalid = 1'b0;
  logic [31:0] if_pc;
  logic [31:0] if_is;
  logic [31:0] if_ppc;
  logic [1:0]  mmif_ok;

  int n_checks = 0;
  int n_pass   = 0;
  int lat      = 1;
  int cnt      = 0;

  exp_t        exp_q[$];
  logic [31:0] acc_q[$];
  logic [7:0]  mem [logic [31:0]];
  logic        m_val [LINES];
  logic [31:0] m_tag [LINES];

  always #5 clk = ~clk;

  if_fetch #(
    .RESET_PC    (RESET_PC),
    .ICACHE_LINES(LINES)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .stl_mm    (stl_mm),
    .jmp_en    (jmp_en),
    .jmp_pc    (jmp_pc),
    .mif_req   (mif_req),
    .mif_addr  (mif_addr),
    .mif_rdata (mif_rdata),
    .mif_rvalid(mif_rvalid),
    .if_pc     (if_pc),
    .if_is     (if_is),
    .if_ppc    (if_ppc),
    .mmif_ok   (mmif_ok)
  );

  function automatic logic [7:0] mem_rd(input logic [31:0] a);
    if (mem.exists(a)) return mem[a];
    return (a[7:0] + 8'h3C) ^ a[15:8] ^ a[31:24];
  endfunction

  function automatic logic [31:0] word_at(input logic [31:0] pc);
    return {mem_rd(pc + 32'd3), mem_rd(pc + 32'd2), mem_rd(pc + 32'd1), mem_rd(pc)};
  endfunction

  // Memory responder: rvalid after `lat` cycles of a held request.
  always @(negedge clk) begin
    if (mif_req) begin
      if (cnt >= lat - 1) begin
        mif_rvalid = 1'b1;
        mif_rdata  = mem_rd(mif_addr);
        cnt        = 0;
      end else begin
        mif_rvalid = 1'b0;
        cnt        = cnt + 1;
      end
    end else begin
      mif_rvalid = 1'b0;
      cnt        = 0;
    end
  end

  // Accepted-byte log and scoreboard; an instruction is consumed at a posedge with stl_mm=0.
  always @(negedge clk) begin
    exp_t e;
    #1;
    if (rst && mif_req && mif_rvalid && !jmp_en) acc_q.push_back(mif_addr);
    if (rst && (mmif_ok != 2'b00) && !stl_mm && !jmp_en) begin
      n_checks++;
      if (exp_q.size() == 0) begin
        $display("FAIL consume: unexpected instruction pc=%h is=%h ok=%b, none required",
                 if_pc, if_is, mmif_ok);
      end else begin
        e = exp_q.pop_front();
        if ({if_pc, if_is, if_ppc, mmif_ok} !== e)
          $display("FAIL consume: got pc=%h is=%h ppc=%h ok=%b want pc=%h is=%h ppc=%h ok=%b",
                   if_pc, if_is, if_ppc, mmif_ok, e.pc, e.is_w, e.ppc, e.ok);
        else n_pass++;
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic model_clear();
    for (int i = 0; i < LINES; i++) m_val[i] = 1'b0;
  endtask

  task automatic expect_fetch(input logic [31:0] pc);
    logic [1:0] ok;
    ok = 2'b01;
`ifdef IF_ICACHE_EN
    begin
      int unsigned li;
      logic [31:0] tg;
      li = (pc >> 2) % LINES;
      tg = pc >> (2 + $clog2(LINES));
      if (pc[1:0] == 2'b00 && m_val[li] && m_tag[li] == tg) ok = 2'b10;
      else if (pc[1:0] == 2'b00) begin
        m_val[li] = 1'b1;
        m_tag[li] = tg;
      end
    end
`endif
    exp_q.push_back('{pc: pc, is_w: word_at(pc), ppc: pc + 32'd4, ok: ok});
  endtask

  task automatic drain(input int budget);
    stl_mm = 1'b0;
    for (int i = 0; i < budget && exp_q.size() != 0; i++) tick();
    n_checks++;
    if (exp_q.size() != 0) $display("FAIL drain: %0d left, required 0", exp_q.size());
    else n_pass++;
    exp_q.delete();
    stl_mm = 1'b1;
  endtask

  task automatic wait_ok(output int cycles);
    cycles = 0;
    while (mmif_ok == 2'b00 && cycles < 200) begin
      tick();
      cycles++;
    end
    n_checks++;
    if (mmif_ok == 2'b00) $display("FAIL wait_ok: mmif_ok=%b after %0d cycles", mmif_ok, cycles);
    else n_pass++;
  endtask

  task automatic do_jump(input logic [31:0] target);
    jmp_en = 1'b1;
    jmp_pc = target;
    tick();
    jmp_en = 1'b0;
  endtask

  task automatic test_reset();
    rst    = 1'b0;
    stl_mm = 1'b1;
    repeat (2) tick();
    n_checks++;
    if ({mif_req, mif_addr, if_pc, if_ppc} !== {1'b0, RESET_PC, RESET_PC, RESET_PC + 32'd4})
      $display("FAIL reset_pc: got req=%b addr=%h pc=%h ppc=%h", mif_req, mif_addr, if_pc, if_ppc);
    else n_pass++;
    n_checks++;
    if ({if_is, mmif_ok} !== {32'h0, 2'b00})
      $display("FAIL reset_out: got is=%h ok=%b want 0/00", if_is, mmif_ok);
    else n_pass++;
    rst = 1'b1;
    model_clear();
  endtask

  task automatic test_first_fetch();
    int cyc;
    mem[32'h0] = 8'h13;
    mem[32'h1] = 8'h05;
    mem[32'h2] = 8'h10;
    mem[32'h3] = 8'h00;
    lat = 1;
    acc_q.delete();
    expect_fetch(32'h0);
    wait_ok(cyc);
    n_checks++;
    if ({if_is, if_ppc, mmif_ok} !== {32'h00100513, 32'h4, 2'b01})
      $display("FAIL first_word: got is=%h ppc=%h ok=%b want 00100513/4/01", if_is, if_ppc, mmif_ok);
    else n_pass++;
    drain(20);
    n_checks++;
    if (acc_q.size() != 4) $display("FAIL first_addr_count: got %0d want 4", acc_q.size());
    else n_pass++;
    for (int k = 0; k < 4 && k < acc_q.size(); k++) begin
      n_checks++;
      if (acc_q[k] !== k) $display("FAIL first_addr: got %h want %h", acc_q[k], k);
      else n_pass++;
    end
    n_checks++;
    if ({mif_req, mif_addr} !== {1'b1, 32'h4})
      $display("FAIL next_fetch: got req=%b addr=%h want 1/00000004", mif_req, mif_addr);
    else n_pass++;
    wait_ok(cyc);
    n_checks++;
    if (cyc != 4) $display("FAIL best_latency: got %0d extra cycles want 4", cyc);
    else n_pass++;
  endtask

  task automatic test_stall();
    for (int i = 0; i < 5; i++) begin
      tick();
      n_checks++;
      if ({mif_req, if_pc, if_is, if_ppc, mmif_ok} !== {1'b0, 32'h4, word_at(32'h4), 32'h8, 2'b01})
        $display("FAIL stall_hold: got req=%b pc=%h is=%h ppc=%h ok=%b",
                 mif_req, if_pc, if_is, if_ppc, mmif_ok);
      else n_pass++;
    end
    expect_fetch(32'h4);
    drain(10);
    n_checks++;
    if ({if_pc, mif_addr, mif_req} !== {32'h8, 32'h8, 1'b1})
      $display("FAIL stall_release: got pc=%h addr=%h req=%b want 8/8/1", if_pc, mif_addr, mif_req);
    else n_pass++;
  endtask

  task automatic test_redirect();
    bit found;
    int cyc;
    lat   = 2;
    found = 0;
    for (int i = 0; i < 40 && !found; i++) begin
      @(negedge clk);
      #2;
      if (mif_req && mif_rvalid && mif_addr == 32'hA) found = 1;
    end
    n_checks++;
    if (!found) $display("FAIL redirect_sync: byte 2 at 0000000a never offered");
    else n_pass++;
    jmp_en = 1'b1;
    jmp_pc = 32'h100;
    tick();
    jmp_en = 1'b0;
    n_checks++;
    if ({mif_req, if_pc, mmif_ok} !== {1'b0, 32'h100, 2'b00})
      $display("FAIL redirect_gap: got req=%b pc=%h ok=%b want 0/100/00", mif_req, if_pc, mmif_ok);
    else n_pass++;
    acc_q.delete();
    expect_fetch(32'h100);
    tick();
    n_checks++;
    if ({mif_req, mif_addr} !== {1'b1, 32'h100})
      $display("FAIL redirect_restart: got req=%b addr=%h want 1/100", mif_req, mif_addr);
    else n_pass++;
    wait_ok(cyc);
    n_checks++;
    if (acc_q.size() != 4) $display("FAIL redirect_bytes: got %0d bytes want 4", acc_q.size());
    else n_pass++;
    for (int k = 0; k < 4 && k < acc_q.size(); k++) begin
      n_checks++;
      if (acc_q[k] !== 32'h100 + k) $display("FAIL redirect_addr: got %h want %h", acc_q[k], 32'h100 + k);
      else n_pass++;
    end
    drain(10);
  endtask

  task automatic test_wrap();
    int cyc;
    lat = 1;
    do_jump(32'hFFFF_FFFC);
    expect_fetch(32'hFFFF_FFFC);
    wait_ok(cyc);
    n_checks++;
    if ({if_pc, if_ppc} !== {32'hFFFF_FFFC, 32'h0})
      $display("FAIL wrap_ppc: got pc=%h ppc=%h want fffffffc/0", if_pc, if_ppc);
    else n_pass++;
    drain(10);
    n_checks++;
    if ({if_pc, mif_addr} !== {32'h0, 32'h0})
      $display("FAIL wrap_next: got pc=%h addr=%h want 0/0", if_pc, mif_addr);
    else n_pass++;
  endtask

  task automatic test_reset_mid();
    bit found;
    lat = 3;
    do_jump(32'h80);
    found = 0;
    for (int i = 0; i < 60 && !found; i++) begin
      @(negedge clk);
      #2;
      if (mif_req && mif_addr == 32'h82) found = 1;
    end
    n_checks++;
    if (!found) $display("FAIL reset_mid_sync: idx 2 of 00000080 never requested");
    else n_pass++;
    rst = 1'b0;
    tick();
    n_checks++;
    if ({mif_req, if_is, mmif_ok, if_pc} !== {1'b0, 32'h0, 2'b00, RESET_PC})
      $display("FAIL reset_mid: got req=%b is=%h ok=%b pc=%h", mif_req, if_is, mmif_ok, if_pc);
    else n_pass++;
    rst = 1'b1;
    lat = 1;
    model_clear();
  endtask

  task automatic test_jmp_hold();
    int cyc;
    wait_ok(cyc);
    n_checks++;
    if ({mmif_ok, if_pc, if_is} !== {2'b01, RESET_PC, word_at(RESET_PC)})
      $display("FAIL after_reset: got ok=%b pc=%h is=%h", mmif_ok, if_pc, if_is);
    else n_pass++;
    tick();
    do_jump(32'h40);
    n_checks++;
    if ({mmif_ok, if_pc, mif_req} !== {2'b00, 32'h40, 1'b0})
      $display("FAIL jmp_over_stall: got ok=%b pc=%h req=%b want 00/40/0", mmif_ok, if_pc, mif_req);
    else n_pass++;
    expect_fetch(32'h40);
    drain(20);
  endtask

  task automatic test_back_to_back();
    for (int k = 0; k < 7; k++) expect_fetch(32'h44 + 32'(4 * k));
    drain(100);
    lat = 2;
    for (int k = 0; k < 3; k++) expect_fetch(32'h60 + 32'(4 * k));
    drain(100);
    lat = 1;
  endtask

`ifdef IF_ICACHE_EN
  task automatic test_icache();
    rst = 1'b0;
    tick();
    rst = 1'b1;
    model_clear();
    expect_fetch(32'h0);
    expect_fetch(32'h4);
    drain(40);
    do_jump(32'h0);
    expect_fetch(32'h0);
    tick();
    n_checks++;
    if (mif_req !== 1'b0) $display("FAIL icache_noreq: got req=%b want 0", mif_req);
    else n_pass++;
    tick();
    n_checks++;
    if (mmif_ok !== 2'b10) $display("FAIL icache_hit: got ok=%b want 10", mmif_ok);
    else n_pass++;
    expect_fetch(32'h4);
    drain(10);
    do_jump(32'(4 * LINES));
    expect_fetch(32'(4 * LINES));
    drain(20);
    do_jump(32'h0);
    expect_fetch(32'h0);
    drain(20);
  endtask
`endif

  initial begin
    model_clear();
    test_reset();
    test_first_fetch();
    test_stall();
    test_redirect();
    test_wrap();
    test_reset_mid();
    test_jmp_hold();
    test_back_to_back();
`ifdef IF_ICACHE_EN
    test_icache();
`endif
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/if_fetch.md
Name: if_fetch

Overview:
- Instruction-fetch stage of the RISC-V pipeline; drives the IF/ID pipeline register inputs (if_pc, if_is, if_ppc, mmif_ok).
- Fetches 32-bit instructions byte-by-byte from the memory controller's byte-wide read port and assembles them little-endian.
- Holds each completed instruction until the IF/ID register consumes it under stl_mm.
- Accepts redirects from EX to abort the current fetch and restart at a new PC.

Parameters:
RESET_PC, 32'h00000000, PC fetched first after reset
ICACHE_LINES, 64, direct-mapped I-cache entries (power of 2; used only with ICACHE_EN)

Ports:
clk  in  1  clock, all state on posedge
rst  in  1  synchronous reset, active-low (rst==0 resets on posedge clk)
stl_mm  in  1  1 = IF/ID holds this cycle; instruction not consumed
jmp_en  in  1  redirect request from EX, single-cycle pulse
jmp_pc  in  32  redirect target
mif_req  out  1  byte read request to memory controller, level
mif_addr  out  32  byte address of the current request
mif_rdata  in  8  returned byte
mif_rvalid  in  1  mif_rdata valid; honoured only in cycles with mif_req=1
if_pc  out  32  PC of the presented instruction
if_is  out  32  assembled instruction
if_ppc  out  32  predicted next PC (if_pc+4, mod 2^32)
mmif_ok  out  2  00 = no instruction, 01 = from memory, 10 = from cache, 11 unused

Behaviour:
- Reset (rst==0 at posedge): state=FETCH, byte index=0, pc=RESET_PC, mif_req=0, mif_addr=RESET_PC, if_pc=RESET_PC, if_ppc=RESET_PC+4, if_is=0, mmif_ok=00. Cache valid bits cleared. Reset wins over every other input, including mid-fetch.
- FETCH state:
  - mif_req=1, mif_addr=pc+idx (idx 0..3); mmif_ok=00.
  - On mif_rvalid, byte k goes to if_is[8k+7:8k] and idx increments.
  - When byte 3 arrives, next state is HOLD and mmif_ok=01 from the next cycle. mif_req drops in that same next cycle.
  - Memory latency per byte is arbitrary (>=1 cycle); there is no timeout.
  - Best case is 4 cycles from entering FETCH to the last byte, so mmif_ok!=00 on the 5th cycle.
- HOLD state:
  - if_pc, if_is, if_ppc and mmif_ok are stable.
  - At a posedge with stl_mm=0: pc <= pc+4, state <= FETCH, idx <= 0, mmif_ok <= 00.
  - At a posedge with stl_mm=1: no change.
- if_pc/if_ppc always reflect the current pc, including during FETCH, so a bubble sampled by IF/ID carries a consistent pc.
- Redirect:
  - jmp_en=1 at a posedge in any non-reset state aborts the current fetch.
  - pc <= jmp_pc, idx <= 0, state <= FETCH, mmif_ok <= 00, mif_req <= 0 for exactly one cycle, then the fetch restarts.
  - A byte whose mif_rvalid coincides with jmp_en is discarded.
  - jmp_en has priority over stl_mm and over completion of byte 3.
- Wrap-around: pc+4 and pc+idx wrap modulo 2^32; 32'hFFFFFFFC followed by +4 gives 0.
- Alignment: no check; a misaligned jmp_pc is fetched as-is.
- mif_addr changes only when mif_req=0 or right after an accepted mif_rvalid.

Optional Feature:
- Macro: IF_ICACHE_EN.
- When defined:
  - Direct-mapped cache, ICACHE_LINES words, index = pc[log2(ICACHE_LINES)+1:2], tag = remaining upper bits, plus a valid bit per line.
  - On entering FETCH with a hit, no memory request is issued; the next cycle is HOLD with if_is=cached word and mmif_ok=10.
  - On a miss, the line is filled when byte 3 arrives; an aborted fetch writes nothing.
- When undefined: no cache storage, every fetch goes to memory, mmif_ok is never 10.

Test Plan:
- Reset with RESET_PC=0, memory 0x00..0x03 = 13,05,10,00, 1-cycle latency, stl_mm=0 -> mif_addr 0,1,2,3; if_is=32'h00100513, mmif_ok=01, if_ppc=4; then a fetch starts at 4.
- stl_mm=1 held 5 cycles while in HOLD -> outputs stable, mif_req=0; release -> pc advances by exactly 4.
- jmp_en=1, jmp_pc=32'h100 coincident with the byte-2 mif_rvalid -> byte discarded, mif_req low for 1 cycle, next mif_addr=0x100, mmif_ok stays 00 until a full 4-byte fetch.
- pc=32'hFFFFFFFC fetched and consumed -> next mif_addr=0, if_ppc shown as 0 during that hold.
- rst=0 asserted while idx=2 -> next cycle mif_req=0, if_is=0, mmif_ok=00, pc=RESET_PC.
- IF_ICACHE_EN: execute loop 0x0->0x4->jmp 0x0 -> second pass mmif_ok=10, no mif_req, 1-cycle fetch; aliasing address (0x0 + 4*ICACHE_LINES) misses and refills.
